// File: rtl/tt_um_spiff42_exp_led_pwm_core.sv
// 8-channel LED PWM with exponential brightness mapping, configured over an I2C slave at 7'h2A.
// Outputs registered one clk after the counter; I2C never stretches SCL, so there is no backpressure.
module tt_um_spiff42_exp_led_pwm_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam logic [6:0] SLAVE_ADDR = 7'h2A;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  scl_sync, sda_sync;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shift, shift_nxt;
    logic [7:0]  rx_byte;
    logic [2:0]  ptr, ptr_nxt;
    logic        ptr_phase, ptr_phase_nxt;
    logic        sda_oe, sda_oe_nxt;
    logic        master_ack, master_ack_nxt;
    logic        wr_en;
    logic [7:0]  bright [8];
    logic [7:0]  shadow [8];
    logic [11:0] pwm_cnt;
    logic        unused;

    assign unused  = &{1'b0, ena, ui_in, uio_in[7:3], uio_in[0]};
    assign uio_out = 8'h00;
    assign uio_oe  = {6'b0, sda_oe, 1'b0};

    // Index 1 is the synchronized level, index 2 its previous value for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 3'b111;
            sda_sync <= 3'b111;
        end else begin
            scl_sync <= {scl_sync[1:0], uio_in[2]};
            sda_sync <= {sda_sync[1:0], uio_in[1]};
        end
    end

    assign scl_rise  = scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] & scl_sync[2];
    assign start_det = scl_sync[1] & scl_sync[2] & sda_sync[2] & ~sda_sync[1];
    assign stop_det  = scl_sync[1] & scl_sync[2] & ~sda_sync[2] & sda_sync[1];
    assign rx_byte   = {shift[6:0], sda_sync[1]};

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift;
        ptr_nxt        = ptr;
        ptr_phase_nxt  = ptr_phase;
        sda_oe_nxt     = sda_oe;
        master_ack_nxt = master_ack;
        wr_en          = 1'b0;
        if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_nxt = 4'd0;
                        if (shift[7:1] == SLAVE_ADDR) begin
                            state_nxt     = ADDR_ACK;
                            sda_oe_nxt    = 1'b1;
                            ptr_phase_nxt = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shift[0]) begin
                            state_nxt  = RD_DATA;
                            shift_nxt  = bright[ptr];
                            sda_oe_nxt = ~bright[ptr][7];
                        end else begin
                            state_nxt  = WR_DATA;
                            sda_oe_nxt = 1'b0;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        // Commit on the 8th rising edge so a later START/STOP cannot tear the byte.
                        if (bit_cnt == 4'd7) begin
                            if (ptr_phase) begin
                                ptr_nxt       = rx_byte[2:0];
                                ptr_phase_nxt = 1'b0;
                            end else begin
                                wr_en   = 1'b1;
                                ptr_nxt = ptr + 3'd1;
                            end
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_nxt   = WR_ACK;
                        bit_cnt_nxt = 4'd0;
                        sda_oe_nxt  = 1'b1;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_nxt  = WR_DATA;
                        sda_oe_nxt = 1'b0;
                    end
                end
                RD_DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_nxt   = RD_ACK;
                            bit_cnt_nxt = 4'd0;
                            sda_oe_nxt  = 1'b0;
                            ptr_nxt     = ptr + 3'd1;
                        end else begin
                            shift_nxt  = {shift[6:0], 1'b0};
                            sda_oe_nxt = ~shift[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        master_ack_nxt = ~sda_sync[1];
                    end else if (scl_fall) begin
                        if (master_ack) begin
                            state_nxt  = RD_DATA;
                            shift_nxt  = bright[ptr];
                            sda_oe_nxt = ~bright[ptr][7];
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            ptr        <= 3'd0;
            ptr_phase  <= 1'b0;
            sda_oe     <= 1'b0;
            master_ack <= 1'b0;
            for (int i = 0; i < 8; i++) bright[i] <= 8'h00;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift      <= shift_nxt;
            ptr        <= ptr_nxt;
            ptr_phase  <= ptr_phase_nxt;
            sda_oe     <= sda_oe_nxt;
            master_ack <= master_ack_nxt;
            if (wr_en) bright[ptr] <= rx_byte;
        end
    end

    function automatic logic [11:0] duty(input logic [7:0] b);
        logic [11:0] base;
        base = {6'd0, 1'b1, b[4:0]};
        if (b[7:5] == 3'd0) duty = {7'd0, b[4:0]};
        else                duty = base << (b[7:5] - 3'd1);
    endfunction

    // Shadow copies load as the counter wraps, so every PWM period uses one consistent duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= 12'd0;
            uo_out  <= 8'h00;
            for (int i = 0; i < 8; i++) shadow[i] <= 8'h00;
        end else begin
            pwm_cnt <= pwm_cnt + 12'd1;
            if (pwm_cnt == 12'hFFF) begin
                for (int i = 0; i < 8; i++) shadow[i] <= bright[i];
            end
            for (int i = 0; i < 8; i++) uo_out[i] <= (pwm_cnt < duty(shadow[i]));
        end
    end
endmodule

// File: tb/tb_tt_um_spiff42_exp_led_pwm_core.sv
// Directed bench: drives an I2C master model on uio_in and measures PWM duty per channel.
module tb_tt_um_spiff42_exp_led_pwm_core;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       scl_m, sda_m;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         hi [8];
    logic       ack;
    logic [7:0] rd;
    logic [7:0] acc_uo, acc_oe, acc_out;

    always #5 clk = ~clk;

    assign uio_in = {5'b0, scl_m, sda_m & ~uio_oe[1], 1'b0};

    tt_um_spiff42_exp_led_pwm_core dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q / 2);
        s = uio_in[1];
        tick(Q / 2);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic a);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        a = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clock_bit(~mack, s);
    endtask

    task automatic measure();
        for (int i = 0; i < 8; i++) hi[i] = 0;
        repeat (4096) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) hi[i] += int'(uo_out[i]);
        end
    endtask

    task automatic check_duty(input string tag, input int e [8]);
        tick(4200);
        measure();
        for (int i = 0; i < 8; i++) chk($sformatf("%s_ch%0d", tag, i), hi[i], e[i]);
    endtask

    int exp_a [8] = '{4032, 0, 0, 0, 0, 0, 0, 0};
    int exp_b [8] = '{4032, 0, 0, 33, 0, 0, 0, 0};
    int exp_c [8] = '{6, 64, 0, 33, 2048, 31, 0, 5};
    int exp_z [8] = '{0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        logic [7:0] aw;
        logic       s;
        aw    = 8'h54;
        rst   = 1'b1;
        ena   = 1'b1;
        ui_in = 8'h00;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(5);
        chk("reset_uo", uo_out, 8'h00);
        chk("reset_oe", uio_oe, 8'h00);
        rst = 1'b0;

        acc_uo = 8'h00; acc_oe = 8'h00; acc_out = 8'h00;
        repeat (8192) begin
            @(negedge clk);
            acc_uo |= uo_out; acc_oe |= uio_oe; acc_out |= uio_out;
        end
        chk("idle_uo", acc_uo, 8'h00);
        chk("idle_oe", acc_oe, 8'h00);
        chk("idle_uio_out", acc_out, 8'h00);

        i2c_start();
        send_byte(8'h54, ack); chk("w0_addr_ack", ack, 1'b1);
        send_byte(8'h00, ack); chk("w0_ptr_ack", ack, 1'b1);
        send_byte(8'hFF, ack); chk("w0_data_ack", ack, 1'b1);
        i2c_stop();
        check_duty("full", exp_a);

        i2c_start();
        send_byte(8'h54, ack); chk("w3_addr_ack", ack, 1'b1);
        send_byte(8'h03, ack); chk("w3_ptr_ack", ack, 1'b1);
        send_byte(8'h21, ack); chk("w3_data_ack", ack, 1'b1);
        i2c_stop();
        check_duty("e1m1", exp_b);

        i2c_start();
        send_byte(8'h54, ack); chk("wrap_addr_ack", ack, 1'b1);
        send_byte(8'h07, ack); chk("wrap_ptr_ack", ack, 1'b1);
        send_byte(8'h05, ack); chk("wrap_d7_ack", ack, 1'b1);
        send_byte(8'h06, ack); chk("wrap_d0_ack", ack, 1'b1);
        i2c_stop();

        i2c_start();
        send_byte(8'h54, ack);
        send_byte(8'h07, ack);
        i2c_start();
        send_byte(8'h55, ack); chk("rd7_addr_ack", ack, 1'b1);
        read_byte(1'b1, rd);   chk("rd7_data", rd, 8'h05);
        read_byte(1'b0, rd);   chk("rd0_wrapped", rd, 8'h06);
        i2c_stop();

        i2c_start();
        send_byte(8'h54, ack);
        send_byte(8'h00, ack);
        i2c_start();
        send_byte(8'h55, ack); chk("rs_addr_ack", ack, 1'b1);
        read_byte(1'b0, rd);   chk("rs_data", rd, 8'h06);
        i2c_stop();

        i2c_start();
        send_byte(8'h56, ack); chk("bad_addr_nack", ack, 1'b0);
        send_byte(8'h02, ack); chk("bad_ptr_nack", ack, 1'b0);
        send_byte(8'h99, ack); chk("bad_data_nack", ack, 1'b0);
        i2c_stop();
        i2c_start();
        send_byte(8'h55, ack);
        read_byte(1'b0, rd);   chk("ptr_persist_rd", rd, 8'h00);
        i2c_stop();

        i2c_start();
        send_byte(8'h54, ack);
        send_byte(8'h01, ack); chk("part_ptr_ack", ack, 1'b1);
        clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b1, s);
        i2c_stop();
        i2c_start();
        send_byte(8'h54, ack);
        send_byte(8'h01, ack);
        i2c_start();
        send_byte(8'h55, ack);
        read_byte(1'b0, rd);   chk("part_discarded", rd, 8'h00);
        i2c_stop();

        i2c_start();
        send_byte(8'h54, ack);
        send_byte(8'h01, ack);
        send_byte(8'h40, ack); chk("after_part_ack", ack, 1'b1);
        i2c_stop();
        i2c_start();
        send_byte(8'h54, ack);
        send_byte(8'h04, ack);
        send_byte(8'hE0, ack);
        send_byte(8'h1F, ack); chk("w45_ack", ack, 1'b1);
        i2c_stop();
        i2c_start();
        send_byte(8'h54, ack);
        send_byte(8'h01, ack);
        i2c_start();
        send_byte(8'h55, ack);
        read_byte(1'b0, rd);   chk("after_part_rd", rd, 8'h40);
        i2c_stop();
        check_duty("mix", exp_c);

        i2c_start();
        for (int i = 7; i >= 0; i--) clock_bit(aw[i], s);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q / 2);
        chk("rst_ack_before", uio_oe[1], 1'b1);
        rst = 1'b1; tick(1);
        chk("rst_sda_release", uio_oe[1], 1'b0);
        tick(2);
        rst = 1'b0; tick(Q / 2);
        scl_m = 1'b0; tick(Q);
        send_byte(8'h00, ack); chk("rst_ignore_ptr", ack, 1'b0);
        send_byte(8'h33, ack); chk("rst_ignore_data", ack, 1'b0);
        i2c_stop();
        chk("rst_uo_cleared", uo_out, 8'h00);
        check_duty("post_rst", exp_z);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
